result_drain: RTL and testbench
===============================

// Module: result_drain
// PURPOSE
//  Receiving end of the systolic array: captures per-column results (column-skewed
//  valids), buffers each column in its own FIFO, and writes them row-major into
//  result SRAM at base_addr. Mirror of the load path that feeds the array from SRAM.
// PARAMETERS
//  DATA_W      16  result word width (two's complement)
//  ARRAY_SIZE  2   columns of the systolic array (= number of column FIFOs)
//  FIFO_DEPTH  8   entries per column FIFO (power of 2)
//  ADDR_W      10  result SRAM address width
// PORTS
//  clk         in   1                  clock
//  rst_n       in   1                  reset, asynchronous, active-low
//  res_valid   in   ARRAY_SIZE         per-column result strobe from array
//  res_data    in   ARRAY_SIZE*DATA_W  column c at [c*DATA_W +: DATA_W]
//  write_start in   1                  start drain (pulse or level, sampled in IDLE)
//  base_addr   in   ADDR_W             first SRAM address, sampled with write_start
//  row_count   in   8                  result rows to write, sampled with write_start
//  sram_wr     out  1                  SRAM write strobe
//  sram_addr   out  ADDR_W             SRAM write address
//  sram_wdata  out  DATA_W             SRAM write data
//  busy        out  1                  high in DRAIN
//  write_done  out  1                  level; set on completion, cleared by next accepted write_start
//  overflow    out  1                  sticky; push to a full FIFO occurred
// BEHAVIOUR
//  - Reset: all outputs 0, FIFOs empty, FSM IDLE, counters 0.
//  - Capture: res_valid[c]=1 pushes res_data column c into FIFO c, every cycle, any state.
//    FIFO full: push dropped, overflow<=1 (cleared only by reset). Full+pop same cycle: push accepted.
//  - FSM IDLE->DRAIN on write_start (latch base_addr,row_count; clear write_done; row=0,col=0).
//    row_count==0: IDLE->DONE directly. write_start outside IDLE ignored.
//  - DRAIN: each cycle, if FIFO[col] non-empty: pop it; next cycle sram_wr=1,
//    sram_addr=base_addr + row*ARRAY_SIZE + col (mod 2^ADDR_W), sram_wdata=popped word.
//    col increments; col==ARRAY_SIZE-1 wraps to 0 and row increments. FIFO[col] empty: stall,
//    no pop, sram_wr=0. Max throughput one write per cycle; pop-to-write latency 1 cycle.
//  - Last pop (row==row_count-1, col==ARRAY_SIZE-1): DRAIN->DONE; write of that word
//    occurs in the DONE-entry cycle. DONE: write_done<=1 next cycle, ->IDLE.
//  - Columns always written in order 0..ARRAY_SIZE-1 regardless of arrival skew.
//  - Residual FIFO contents after completion are retained for the next drain.
//  - sram_addr/sram_wdata hold last value when sram_wr=0.
// CONFIGURATION
//  RESULT_RELU_EN defined: popped word with sign bit set written as 0 (ReLU on write path,
//  no added latency). Undefined: words written unmodified.
// STRUCTURE
//  - Shared package/header sys_pkg: DATA_W, ARRAY_SIZE, ADDR_W, FIFO_DEPTH defaults,
//    FSM state encodings (IDLE, DRAIN, DONE).
//  - Sub-module result_fifo: synchronous first-word-fall-through FIFO (push, pop, dout,
//    full, empty), one instance per column via generate.
//  - Top: FSM, row/col counters, address adder, output register stage.
// TESTING
//  1 Basic: base_addr=0x010,row_count=2, cols push 1,2 then 3,4 aligned -> writes
//    (0x010,1),(0x011,2),(0x012,3),(0x013,4); write_done=1, busy=0.
//  2 Skew: col1 valids lag col0 by 3 cycles -> same SRAM image, sram_wr gaps while col1 empty.
//  3 Overflow: 9 pushes to col0 with no drain -> overflow=1, 9th word lost, first 8 intact.
//  4 Wrap: base_addr=0x3FE,row_count=2 -> addresses 0x3FE,0x3FF,0x000,0x001.
//  5 Zero rows / re-start: row_count=0 -> write_done within 2 cycles, no sram_wr;
//    write_start while busy ignored; rst_n low mid-DRAIN -> all outputs 0, FIFOs empty.
//  6 RESULT_RELU_EN: push 0xFFF0,0x0005 -> written 0x0000,0x0005 (unmodified without macro).

Source files
------------

// File: rtl/sys_pkg.sv
// rtl/sys_pkg.sv - shared defaults and FSM encodings for the result drain path
package sys_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ARRAY_SIZE = 2;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_ADDR_W     = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous first-word-fall-through FIFO, one per array column
module result_fifo
  import sys_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = idx_w(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/result_drain.sv
// rtl/result_drain.sv - drains per-column result FIFOs row-major into result SRAM
// Optional RESULT_RELU_EN: words with the sign bit set are written as zero.
module result_drain
  import sys_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ARRAY_SIZE-1:0]        res_valid,
  input  logic [ARRAY_SIZE*DATA_W-1:0] res_data,
  input  logic                         write_start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [7:0]                   row_count,
  output logic                         sram_wr,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [DATA_W-1:0]            sram_wdata,
  output logic                         busy,
  output logic                         write_done,
  output logic                         overflow
);

  localparam int COL_W = idx_w(ARRAY_SIZE);

  logic [ARRAY_SIZE-1:0] fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0]     fifo_dout [ARRAY_SIZE];

  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
    result_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (res_valid[c]),
      .din   (res_data[c*DATA_W +: DATA_W]),
      .pop   (fifo_pop[c]),
      .dout  (fifo_dout[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  logic [1:0]        state_q, state_d;
  logic [7:0]        row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        rows_q, rows_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cur_empty;
  logic [DATA_W-1:0] pop_word, wr_word;

  always_comb begin
    cur_empty = 1'b1;
    pop_word  = '0;
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      if (col_q == COL_W'(c)) begin
        cur_empty = fifo_empty[c];
        pop_word  = fifo_dout[c];
      end
    end
`ifdef RESULT_RELU_EN
    wr_word = pop_word[DATA_W-1] ? '0 : pop_word;
`else
    wr_word = pop_word;
`endif
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    base_d   = base_q;
    rows_d   = rows_q;
    done_d   = done_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    fifo_pop = '0;
    case (state_q)
      ST_IDLE: begin
        if (write_start) begin
          base_d  = base_addr;
          rows_d  = row_count;
          done_d  = 1'b0;
          row_d   = '0;
          col_d   = '0;
          state_d = (row_count == 8'd0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Columns are serviced strictly in order; an empty column stalls the drain.
        if (!cur_empty) begin
          fifo_pop = ARRAY_SIZE'(1) << col_q;
          wr_d     = 1'b1;
          addr_d   = base_q + ADDR_W'(row_q) * ADDR_W'(ARRAY_SIZE) + ADDR_W'(col_q);
          wdata_d  = wr_word;
          if (col_q == COL_W'(ARRAY_SIZE - 1)) begin
            col_d = '0;
            row_d = row_q + 8'd1;
            if (row_q == rows_q - 8'd1) state_d = ST_DONE;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ovf_d = ovf_q | (|(res_valid & fifo_full & ~fifo_pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      base_q  <= '0;
      rows_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign sram_wr    = wr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign busy       = (state_q == ST_DRAIN);
  assign write_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - directed self-checking bench for result_drain
module tb_result_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  res_valid;
  logic [31:0] res_data;
  logic        write_start;
  logic [9:0]  base_addr;
  logic [7:0]  row_count;
  logic        sram_wr;
  logic [9:0]  sram_addr;
  logic [15:0] sram_wdata;
  logic        busy;
  logic        write_done;
  logic        overflow;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [9:0]  wq_addr [$];
  logic [15:0] wq_data [$];
  int          wq_cyc  [$];

  result_drain dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .write_start (write_start),
    .base_addr   (base_addr),
    .row_count   (row_count),
    .sram_wr     (sram_wr),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .busy        (busy),
    .write_done  (write_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sram_wr === 1'b1) begin
      wq_addr.push_back(sram_addr);
      wq_data.push_back(sram_wdata);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic drive(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                       input logic st, input logic [9:0] b, input logic [7:0] r);
    @(negedge clk);
    res_valid   = v;
    res_data    = {d1, d0};
    write_start = st;
    base_addr   = b;
    row_count   = r;
  endtask

  task automatic idle();
    drive(2'b00, 16'h0, 16'h0, 1'b0, 10'h0, 8'h0);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (write_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (write_done === 1'b1);
  endtask

  task automatic reset_dut();
    rst_n       = 1'b0;
    res_valid   = '0;
    res_data    = '0;
    write_start = 1'b0;
    base_addr   = '0;
    row_count   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({sram_wr, sram_addr, sram_wdata, busy, write_done, overflow} !== 30'd0)
      $display("FAIL reset_outputs got=%h want=0",
               {sram_wr, sram_addr, sram_wdata, busy, write_done, overflow});
    else passed++;
  endtask

  task automatic test_basic();
    logic [9:0]  ea [4];
    logic [15:0] ed [4];
    bit ok;
    ea = '{10'h010, 10'h011, 10'h012, 10'h013};
    ed = '{16'd1, 16'd2, 16'd3, 16'd4};
    clear_log();
    drive(2'b11, 16'd1, 16'd2, 1'b0, 10'h0, 8'd0);
    drive(2'b11, 16'd3, 16'd4, 1'b0, 10'h0, 8'd0);
    drive(2'b00, 16'd0, 16'd0, 1'b1, 10'h010, 8'd2);
    idle();
    wait_done(50, ok);
    checks++;
    if (!ok) $display("FAIL basic_done_timeout got=%b want=1", write_done); else passed++;
    checks++;
    if (wq_addr.size() != 4) $display("FAIL basic_count got=%0d want=4", wq_addr.size());
    else passed++;
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      checks++;
      if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i])
        $display("FAIL basic_write%0d got=(%h,%h) want=(%h,%h)", i, wq_addr[i], wq_data[i], ea[i], ed[i]);
      else passed++;
    end
    checks++;
    if ({busy, write_done, overflow} !== 3'b010)
      $display("FAIL basic_status got=%b want=010", {busy, write_done, overflow});
    else passed++;
  endtask

  task automatic test_skew();
    logic [9:0]  ea [4];
    logic [15:0] ed [4];
    bit ok;
    ea = '{10'h020, 10'h021, 10'h022, 10'h023};
    ed = '{16'h0011, 16'h0012, 16'h0013, 16'h0014};
    clear_log();
    drive(2'b01, 16'h0011, 16'h0, 1'b1, 10'h020, 8'd2);
    drive(2'b01, 16'h0013, 16'h0, 1'b0, 10'h0, 8'd0);
    idle();
    drive(2'b10, 16'h0, 16'h0012, 1'b0, 10'h0, 8'd0);
    drive(2'b10, 16'h0, 16'h0014, 1'b0, 10'h0, 8'd0);
    idle();
    wait_done(50, ok);
    checks++;
    if (!ok) $display("FAIL skew_done_timeout got=%b want=1", write_done); else passed++;
    checks++;
    if (wq_addr.size() != 4) $display("FAIL skew_count got=%0d want=4", wq_addr.size());
    else passed++;
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      checks++;
      if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i])
        $display("FAIL skew_write%0d got=(%h,%h) want=(%h,%h)", i, wq_addr[i], wq_data[i], ea[i], ed[i]);
      else passed++;
    end
    if (wq_cyc.size() == 4) begin
      checks++;
      if (wq_cyc[3] - wq_cyc[0] != 5)
        $display("FAIL skew_span got=%0d want=5", wq_cyc[3] - wq_cyc[0]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [9:0]  ea;
    logic [15:0] ed;
    clear_log();
    for (int i = 0; i < 9; i++)
      drive((i < 8) ? 2'b11 : 2'b01, 16'(16'h0100 + i), 16'(16'h0200 + i), 1'b0, 10'h0, 8'd0);
    idle();
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_set got=%b want=1", overflow); else passed++;
    drive(2'b00, 16'h0, 16'h0, 1'b1, 10'h100, 8'd8);
    idle();
    wait_done(100, ok);
    checks++;
    if (!ok) $display("FAIL ovf_done_timeout got=%b want=1", write_done); else passed++;
    checks++;
    if (wq_addr.size() != 16) $display("FAIL ovf_count got=%0d want=16", wq_addr.size());
    else passed++;
    for (int i = 0; i < 16 && i < wq_addr.size(); i++) begin
      ea = 10'(10'h100 + i);
      ed = (i % 2 == 0) ? 16'(16'h0100 + i / 2) : 16'(16'h0200 + i / 2);
      checks++;
      if (wq_addr[i] !== ea || wq_data[i] !== ed)
        $display("FAIL ovf_write%0d got=(%h,%h) want=(%h,%h)", i, wq_addr[i], wq_data[i], ea, ed);
      else passed++;
    end
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", overflow); else passed++;
  endtask

  task automatic test_wrap();
    logic [9:0]  ea [4];
    logic [15:0] ed [4];
    bit ok;
    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    ed = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    reset_dut();
    checks++;
    if (overflow !== 1'b0) $display("FAIL wrap_ovf_cleared got=%b want=0", overflow); else passed++;
    drive(2'b11, 16'h00A1, 16'h00A2, 1'b1, 10'h3FE, 8'd2);
    drive(2'b11, 16'h00A3, 16'h00A4, 1'b0, 10'h0, 8'd0);
    idle();
    wait_done(50, ok);
    checks++;
    if (!ok) $display("FAIL wrap_done_timeout got=%b want=1", write_done); else passed++;
    checks++;
    if (wq_addr.size() != 4) $display("FAIL wrap_count got=%0d want=4", wq_addr.size());
    else passed++;
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      checks++;
      if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i])
        $display("FAIL wrap_write%0d got=(%h,%h) want=(%h,%h)", i, wq_addr[i], wq_data[i], ea[i], ed[i]);
      else passed++;
    end
  endtask

  task automatic test_zero_rows();
    clear_log();
    drive(2'b00, 16'h0, 16'h0, 1'b1, 10'h040, 8'd0);
    idle();
    checks++;
    if ({busy, write_done} !== 2'b00) $display("FAIL zero_cleared got=%b want=00", {busy, write_done});
    else passed++;
    idle();
    checks++;
    if (write_done !== 1'b1) $display("FAIL zero_done got=%b want=1", write_done); else passed++;
    idle();
    checks++;
    if (wq_addr.size() != 0) $display("FAIL zero_no_writes got=%0d want=0", wq_addr.size());
    else passed++;
  endtask

  task automatic test_busy_ignored();
    bit ok;
    clear_log();
    drive(2'b00, 16'h0, 16'h0, 1'b1, 10'h050, 8'd1);
    drive(2'b00, 16'h0, 16'h0, 1'b1, 10'h070, 8'd1);
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_high got=%b want=1", busy); else passed++;
    drive(2'b11, 16'h0007, 16'h0008, 1'b0, 10'h0, 8'd0);
    idle();
    wait_done(50, ok);
    checks++;
    if (!ok) $display("FAIL busy_done_timeout got=%b want=1", write_done); else passed++;
    checks++;
    if (wq_addr.size() != 2 || wq_addr[0] !== 10'h050 || wq_data[0] !== 16'h0007 ||
        wq_addr[1] !== 10'h051 || wq_data[1] !== 16'h0008)
      $display("FAIL busy_writes got=%0d writes first=(%h,%h) want=2 writes (050,0007),(051,0008)",
               wq_addr.size(), wq_addr.size() > 0 ? wq_addr[0] : 10'h0, wq_addr.size() > 0 ? wq_data[0] : 16'h0);
    else passed++;
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    clear_log();
    drive(2'b01, 16'h0009, 16'h0, 1'b1, 10'h060, 8'd1);
    drive(2'b01, 16'h000C, 16'h0, 1'b0, 10'h0, 8'd0);
    idle();
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy got=%b want=1", busy); else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sram_wr, sram_addr, sram_wdata, busy, write_done, overflow} !== 30'd0)
      $display("FAIL mid_reset_outputs got=%h want=0",
               {sram_wr, sram_addr, sram_wdata, busy, write_done, overflow});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    drive(2'b11, 16'h000A, 16'h000B, 1'b1, 10'h000, 8'd1);
    idle();
    wait_done(50, ok);
    checks++;
    if (!ok) $display("FAIL mid_done_timeout got=%b want=1", write_done); else passed++;
    checks++;
    if (wq_addr.size() != 2 || wq_addr[0] !== 10'h000 || wq_data[0] !== 16'h000A ||
        wq_addr[1] !== 10'h001 || wq_data[1] !== 16'h000B)
      $display("FAIL mid_fifo_flushed got=%0d writes first=(%h,%h) want=2 writes (000,000a),(001,000b)",
               wq_addr.size(), wq_addr.size() > 0 ? wq_addr[0] : 10'h0, wq_addr.size() > 0 ? wq_data[0] : 16'h0);
    else passed++;
  endtask

  task automatic test_relu();
    bit ok;
    logic [15:0] exp0;
`ifdef RESULT_RELU_EN
    exp0 = 16'h0000;
`else
    exp0 = 16'hFFF0;
`endif
    clear_log();
    drive(2'b11, 16'hFFF0, 16'h0005, 1'b1, 10'h080, 8'd1);
    idle();
    wait_done(50, ok);
    checks++;
    if (!ok) $display("FAIL relu_done_timeout got=%b want=1", write_done); else passed++;
    checks++;
    if (wq_data.size() != 2 || wq_data[0] !== exp0 || wq_data[1] !== 16'h0005 || wq_addr[0] !== 10'h080)
      $display("FAIL relu_data got=%0d writes first=%h want=2 writes %h,0005",
               wq_data.size(), wq_data.size() > 0 ? wq_data[0] : 16'h0, exp0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_overflow();
    test_wrap();
    test_zero_rows();
    test_busy_ignored();
    test_reset_mid_drain();
    test_relu();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
